// File: rtl/audio_ram_pkg.sv
// audio_ram_pkg: shared address width, FSM state encoding and timeout width helper
package audio_ram_pkg;
  localparam int RAM_ADDR_W = 26;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REC       = 3'd1,
    S_REC_WR    = 3'd2,
    S_PLAY_REQ  = 3'd3,
    S_PLAY_WAIT = 3'd4,
    S_PLAY_ACK  = 3'd5,
    S_PLAY_HOLD = 3'd6
  } state_e;
  function automatic int to_width(input int t);
    return $clog2(t + 1);
  endfunction
endpackage

// File: rtl/audio_ram_sequencer.sv
// audio_ram_sequencer: records audio samples into the RAM wrapper and plays them back one read at a time
module audio_ram_sequencer
  import audio_ram_pkg::*;
#(
  parameter int DATA_BYTE_WIDTH = 2,
  parameter int RD_TIMEOUT      = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rdy,
  input  logic                          rd_data_pres,
  input  logic [8*DATA_BYTE_WIDTH-1:0]  ram_rd_data,
  input  logic [RAM_ADDR_W-1:0]         max_ram_address,
  output logic [RAM_ADDR_W-1:0]         address,
  output logic [8*DATA_BYTE_WIDTH-1:0]  data_in,
  output logic                          write_enable,
  output logic                          read_request,
  output logic                          read_ack,
  input  logic                          rec_start,
  input  logic                          play_start,
  input  logic                          stop,
  input  logic [8*DATA_BYTE_WIDTH-1:0]  sample_in,
  input  logic                          sample_in_valid,
  output logic [8*DATA_BYTE_WIDTH-1:0]  sample_out,
  output logic                          sample_out_valid,
  input  logic                          sample_out_req,
  output logic                          recording,
  output logic                          playing,
  output logic [RAM_ADDR_W-1:0]         rec_length,
  output logic                          overflow,
  output logic                          timeout_err
);
  localparam int SW   = 8 * DATA_BYTE_WIDTH;
  localparam int TO_W = to_width(RD_TIMEOUT);
  typedef logic [RAM_ADDR_W-1:0] addr_t;
  state_e          state_q, state_d;
  addr_t           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, address_q, address_d, rec_length_q, rec_length_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0]   data_in_q, data_in_d, sample_out_q, sample_out_d;
  logic            write_enable_q, write_enable_d, read_request_q, read_request_d, read_ack_q, read_ack_d;
  logic            sample_out_valid_q, sample_out_valid_d, recording_q, recording_d, playing_q, playing_d;
  logic            overflow_q, overflow_d, timeout_err_q, timeout_err_d, stop_pend_q, stop_pend_d;
  // next-state and registered-output logic; loss of rdy overrides every other transition
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    address_d = address_q;
    rec_length_d = rec_length_q;
    to_cnt_d = to_cnt_q;
    data_in_d = data_in_q;
    sample_out_d = sample_out_q;
    sample_out_valid_d = sample_out_valid_q;
    recording_d = recording_q;
    playing_d = playing_q;
    overflow_d = overflow_q;
    timeout_err_d = timeout_err_q;
    stop_pend_d = stop_pend_q;
    write_enable_d = 1'b0;
    read_request_d = 1'b0;
    read_ack_d = 1'b0;
    if (state_q != S_IDLE && !rdy) begin
      state_d = S_IDLE;
      sample_out_valid_d = 1'b0;
      recording_d = 1'b0;
      playing_d = 1'b0;
      stop_pend_d = 1'b0;
      if (recording_q) rec_length_d = wr_ptr_q + addr_t'(state_q == S_REC_WR);
      if (state_q == S_PLAY_REQ || state_q == S_PLAY_WAIT) timeout_err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          stop_pend_d = 1'b0;
          if (rdy && rec_start) begin
            state_d = S_REC;
            wr_ptr_d = '0;
            recording_d = 1'b1;
            overflow_d = 1'b0;
            timeout_err_d = 1'b0;
          end else if (rdy && play_start && rec_length_q != '0) begin
            state_d = S_PLAY_REQ;
            rd_ptr_d = '0;
            address_d = '0;
            read_request_d = 1'b1;
            playing_d = 1'b1;
            overflow_d = 1'b0;
            timeout_err_d = 1'b0;
          end
        end
        S_REC: begin
          if (stop) begin
            state_d = S_IDLE;
            recording_d = 1'b0;
            rec_length_d = wr_ptr_q;
          end else if (sample_in_valid) begin
            state_d = S_REC_WR;
            write_enable_d = 1'b1;
            address_d = wr_ptr_q;
            data_in_d = sample_in;
          end
        end
        S_REC_WR: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (sample_in_valid) overflow_d = 1'b1;
          if (stop || wr_ptr_q == max_ram_address) begin
            state_d = S_IDLE;
            recording_d = 1'b0;
            rec_length_d = wr_ptr_q + 1'b1;
          end else begin
            state_d = S_REC;
          end
        end
        S_PLAY_REQ: begin
          state_d = S_PLAY_WAIT;
          to_cnt_d = '0;
          if (stop) stop_pend_d = 1'b1;
        end
        S_PLAY_WAIT: begin
          if (stop) stop_pend_d = 1'b1;
          if (rd_data_pres) begin
            state_d = S_PLAY_ACK;
            read_ack_d = 1'b1;
          end else if (to_cnt_q == TO_W'(RD_TIMEOUT - 1)) begin
            state_d = S_IDLE;
            playing_d = 1'b0;
            timeout_err_d = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        S_PLAY_ACK: begin
          if (stop_pend_q || stop) begin
            state_d = S_IDLE;
            playing_d = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_PLAY_HOLD;
            sample_out_d = ram_rd_data;
            sample_out_valid_d = 1'b1;
          end
        end
        S_PLAY_HOLD: begin
          if (stop) begin
            state_d = S_IDLE;
            sample_out_valid_d = 1'b0;
            playing_d = 1'b0;
          end else if (sample_out_req) begin
            sample_out_valid_d = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_ptr_q == rec_length_q - 1'b1) begin
              state_d = S_IDLE;
              playing_d = 1'b0;
            end else begin
              state_d = S_PLAY_REQ;
              read_request_d = 1'b1;
              address_d = rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      address_q <= '0;
      rec_length_q <= '0;
      to_cnt_q <= '0;
      data_in_q <= '0;
      sample_out_q <= '0;
      sample_out_valid_q <= 1'b0;
      write_enable_q <= 1'b0;
      read_request_q <= 1'b0;
      read_ack_q <= 1'b0;
      recording_q <= 1'b0;
      playing_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_err_q <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      address_q <= address_d;
      rec_length_q <= rec_length_d;
      to_cnt_q <= to_cnt_d;
      data_in_q <= data_in_d;
      sample_out_q <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      write_enable_q <= write_enable_d;
      read_request_q <= read_request_d;
      read_ack_q <= read_ack_d;
      recording_q <= recording_d;
      playing_q <= playing_d;
      overflow_q <= overflow_d;
      timeout_err_q <= timeout_err_d;
      stop_pend_q <= stop_pend_d;
    end
  end
  assign address = address_q;
  assign data_in = data_in_q;
  assign write_enable = write_enable_q;
  assign read_request = read_request_q;
  assign read_ack = read_ack_q;
  assign sample_out = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign recording = recording_q;
  assign playing = playing_q;
  assign rec_length = rec_length_q;
  assign overflow = overflow_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_audio_ram_sequencer.sv
`timescale 1ns/1ps
// tb_audio_ram_sequencer: randomized record/playback against a RAM wrapper model and a sample scoreboard
module tb_audio_ram_sequencer;
  logic clk = 1'b0, reset = 1'b0, rdy = 1'b0, rd_data_pres = 1'b0;
  logic [15:0] ram_rd_data = '0, sample_in = '0, data_in, sample_out;
  logic [25:0] max_ram_address = 26'd1000, address, rec_length;
  logic write_enable, read_request, read_ack, sample_out_valid, recording, playing, overflow, timeout_err;
  logic rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, sample_in_valid = 1'b0, sample_out_req = 1'b0;
  int checks = 0, errors = 0;
  logic [15:0] rec_q[$];
  logic [15:0] mem [logic [25:0]];
  logic [25:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [25:0] pend_addr = '0;
  int pend_cnt = 0, rd_lat = 6, n_rack = 0, ack_addr_err = 0;
  bit rd_never = 1'b0;

  audio_ram_sequencer dut (
    .clk(clk), .reset(reset), .rdy(rdy), .rd_data_pres(rd_data_pres), .ram_rd_data(ram_rd_data),
    .max_ram_address(max_ram_address), .address(address), .data_in(data_in),
    .write_enable(write_enable), .read_request(read_request), .read_ack(read_ack),
    .rec_start(rec_start), .play_start(play_start), .stop(stop), .sample_in(sample_in),
    .sample_in_valid(sample_in_valid), .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .sample_out_req(sample_out_req), .recording(recording), .playing(playing),
    .rec_length(rec_length), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // RAM wrapper model: stores writes, answers each read after rd_lat cycles, pops on read_ack
  always @(negedge clk) begin
    if (!reset) begin
      pend_cnt = 0;
      rd_data_pres = 1'b0;
    end else begin
      if (write_enable) begin
        mem[address] = data_in;
        wa_q.push_back(address);
        wd_q.push_back(data_in);
      end
      if (read_request) begin
        pend_cnt = rd_lat;
        pend_addr = address;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0 && !rd_never) begin
          rd_data_pres = 1'b1;
          ram_rd_data = mem[pend_addr];
        end
      end
      if (read_ack) begin
        n_rack++;
        if (address !== pend_addr) ack_addr_err++;
        rd_data_pres = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] outs();
    return 128'({address, data_in, write_enable, read_request, read_ack, sample_out, sample_out_valid,
                 recording, playing, rec_length, overflow, timeout_err});
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 100 && !sample_out_valid; i++) tick();
    ok = sample_out_valid;
  endtask

  task automatic record_n(input int n, input int gap, input bit fixed, output int w0);
    rec_q.delete();
    w0 = wa_q.size();
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    check("rec_on", 128'(recording), 128'(1));
    for (int i = 0; i < n; i++) begin
      int g;
      sample_in = fixed ? 16'((i + 1) * 16'h1111) : 16'($urandom);
      rec_q.push_back(sample_in);
      sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
      g = (gap != 0) ? gap : int'($urandom_range(2, 5));
      repeat (g - 1) tick();
    end
  endtask

  task automatic check_writes(input int w0, input int n);
    check("n_writes", 128'(wa_q.size() - w0), 128'(n));
    for (int i = 0; i < n && w0 + i < wa_q.size(); i++) begin
      check("wr_addr", 128'(wa_q[w0 + i]), 128'(i));
      check("wr_data", 128'(wd_q[w0 + i]), 128'(rec_q[i]));
    end
  endtask

  task automatic play_all(input int n, input int lat, input int dly);
    int r0;
    bit ok;
    rd_lat = lat;
    r0 = n_rack;
    play_start = 1'b1; tick(); play_start = 1'b0;
    check("play_on", 128'({playing, read_request, address}), 128'({1'b1, 1'b1, 26'd0}));
    for (int k = 0; k < n; k++) begin
      int d;
      wait_valid(ok);
      check("valid_seen", 128'(ok), 128'(1));
      check("sample", 128'(sample_out), 128'(rec_q[k]));
      d = (dly >= 0) ? dly : int'($urandom_range(0, 3));
      for (int j = 0; j < d; j++) begin
        tick();
        check("hold", 128'({sample_out_valid, sample_out}), 128'({1'b1, rec_q[k]}));
      end
      sample_out_req = 1'b1; tick(); sample_out_req = 1'b0;
      check("consumed", 128'(sample_out_valid), 128'(0));
    end
    check("play_off", 128'(playing), 128'(0));
    check("n_acks", 128'(n_rack - r0), 128'(n));
  endtask

  initial begin
    int w0, t, r0, n;
    bit ok, vseen;
    repeat (2) tick();
    check("reset_outs", outs(), 128'(0));
    reset = 1'b1; rdy = 1'b1; tick();
    // fixed recording and playback
    record_n(5, 3, 1'b1, w0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("rec_stop", 128'({recording, rec_length, overflow}), 128'({1'b0, 26'd5, 1'b0}));
    check_writes(w0, 5);
    play_all(5, 6, 2);
    // back-to-back samples overflow
    w0 = wa_q.size();
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    sample_in = 16'hAAAA; sample_in_valid = 1'b1; tick();
    sample_in = 16'hBBBB; tick(); sample_in_valid = 1'b0; tick();
    check("ovf_set", 128'(overflow), 128'(1));
    stop = 1'b1; tick(); stop = 1'b0;
    check("ovf_writes", 128'(wa_q.size() - w0), 128'(1));
    check("ovf_len", 128'(rec_length), 128'(1));
    // randomized rounds
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(3, 8));
      record_n(n, 0, 1'b0, w0);
      stop = 1'b1; tick(); stop = 1'b0;
      check("rnd_len", 128'(rec_length), 128'(n));
      check_writes(w0, n);
      play_all(n, int'($urandom_range(1, 10)), -1);
    end
    // memory full
    max_ram_address = 26'd3;
    record_n(6, 3, 1'b1, w0);
    check_writes(w0, 4);
    check("full_state", 128'({recording, rec_length, overflow}), 128'({1'b0, 26'd4, 1'b0}));
    max_ram_address = 26'd1000;
    // read timeout
    rd_never = 1'b1;
    r0 = n_rack;
    play_start = 1'b1; tick(); play_start = 1'b0;
    t = 0;
    while (playing && t < 1100) begin tick(); t++; end
    check("to_cycles", 128'(t), 128'(1024));
    check("to_err", 128'({timeout_err, playing}), 128'({1'b1, 1'b0}));
    check("to_no_ack", 128'(n_rack - r0), 128'(0));
    rd_never = 1'b0;
    // stop while waiting drains exactly one read
    rd_lat = 10;
    r0 = n_rack;
    play_start = 1'b1; tick(); play_start = 1'b0;
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    vseen = 1'b0; t = 0;
    while (playing && t < 50) begin vseen |= sample_out_valid; tick(); t++; end
    vseen |= sample_out_valid;
    check("stop_idle", 128'(playing), 128'(0));
    check("stop_ack", 128'(n_rack - r0), 128'(1));
    check("stop_novalid", 128'(vseen), 128'(0));
    check("stop_to_clr", 128'(timeout_err), 128'(0));
    // commands ignored without rdy
    rdy = 1'b0; rec_start = 1'b1; play_start = 1'b1; tick();
    rec_start = 1'b0; play_start = 1'b0;
    check("nordy_ign", 128'({recording, playing}), 128'(0));
    rdy = 1'b1;
    // reset in the middle of a held sample
    play_start = 1'b1; tick(); play_start = 1'b0;
    wait_valid(ok);
    check("hold_reached", 128'(ok), 128'(1));
    reset = 1'b0; tick();
    check("midreset_outs", outs(), 128'(0));
    reset = 1'b1; tick();
    play_start = 1'b1; tick(); play_start = 1'b0;
    check("play_empty_ign", 128'({playing, read_request}), 128'(0));
    // rdy loss during recording keeps the count written so far
    record_n(2, 3, 1'b0, w0);
    rdy = 1'b0; tick(); rdy = 1'b1;
    check("rdy_drop", 128'({recording, rec_length}), 128'({1'b0, 26'd2}));
    check("ack_addr", 128'(ack_addr_err), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
